// File: rtl/scmp_microcode_seq.sv
// SC/MP micro-PC sequencer: picks the next microcode ROM address, stalls on bus
// handshakes and HALT, and takes the interrupt decision at instruction fetch.
module scmp_microcode_seq #(
  parameter int               UPC_W      = 8,
  parameter logic [UPC_W-1:0] RESET_ADDR = 8'h00,
  parameter logic [UPC_W-1:0] FETCH_ADDR = 8'h01,
  parameter logic [UPC_W-1:0] INT_ADDR   = 8'h02
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [UPC_W-1:0] op_pc,
  input  logic [2:0]       mode,
  input  logic [UPC_W-1:0] target,
  input  logic             cond,
  input  logic             bus_req,
  input  logic             bus_ack,
  input  logic             irq,
  input  logic             ie,
  input  logic             cont,
  output logic [UPC_W-1:0] upc,
  output logic             stall,
  output logic             irq_taken,
  output logic             halted
);

  typedef enum logic [1:0] {RUN, BUSWAIT, HALTED} state_t;
  typedef enum logic [2:0] {
    M_NEXT, M_JUMP, M_DISPATCH, M_COND, M_CALL, M_RET, M_FETCH, M_HALT
  } mode_t;

  state_t           state_q, state_d;
  logic [UPC_W-1:0] upc_q, upc_d;
  logic [UPC_W-1:0] ret_q, ret_d;
  logic             irq_taken_q, irq_taken_d;
  logic             halted_q, halted_d;
  logic [UPC_W-1:0] upc_inc;
  logic             adv;

  assign upc_inc = upc_q + UPC_W'(1);

  always_comb begin
    state_d     = state_q;
    upc_d       = upc_q;
    ret_d       = ret_q;
    halted_d    = halted_q;
    irq_taken_d = 1'b0;
    stall       = 1'b0;
    adv         = 1'b0;

    unique case (state_q)
      RUN: begin
        if (bus_req && !bus_ack) begin
          stall   = 1'b1;
          state_d = BUSWAIT;
        end else begin
          adv = 1'b1;
        end
      end
      BUSWAIT: begin
        if (!bus_ack) begin
          stall = 1'b1;
        end else begin
          adv     = 1'b1;
          state_d = RUN;
        end
      end
      HALTED: begin
        if (cont) begin
          upc_d    = upc_inc;
          halted_d = 1'b0;
          state_d  = RUN;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    // Mode is only honoured on a cycle the bus lets us advance.
    if (adv) begin
      unique case (mode_t'(mode))
        M_NEXT:     upc_d = upc_inc;
        M_JUMP:     upc_d = target;
        M_DISPATCH: upc_d = op_pc;
        M_COND:     upc_d = cond ? target : upc_inc;
        M_CALL: begin
          ret_d = upc_inc;
          upc_d = target;
        end
        M_RET:      upc_d = ret_q;
        M_FETCH: begin
          if (irq && ie) begin
            upc_d       = INT_ADDR;
            irq_taken_d = 1'b1;
          end else begin
            upc_d = FETCH_ADDR;
          end
        end
        M_HALT: begin
          stall    = 1'b1;
          halted_d = 1'b1;
          state_d  = HALTED;
        end
        default: upc_d = upc_inc;
      endcase
    end

    // Reset always loads, so the sequencer is never reported stalled under it.
    if (!rst_n) stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      upc_q       <= RESET_ADDR;
      ret_q       <= '0;
      irq_taken_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      upc_q       <= upc_d;
      ret_q       <= ret_d;
      irq_taken_q <= irq_taken_d;
      halted_q    <= halted_d;
    end
  end

  assign upc       = upc_q;
  assign irq_taken = irq_taken_q;
  assign halted    = halted_q;

endmodule

// File: tb/tb_scmp_microcode_seq.sv
// Directed bench for scmp_microcode_seq: each stimulus cycle pushes the expected
// outputs for that cycle; a negedge monitor pops and compares.
module tb_scmp_microcode_seq;

  localparam logic [2:0] NEXT = 3'd0, JUMP = 3'd1, DISP = 3'd2, CONDM = 3'd3,
                         CALL = 3'd4, RET = 3'd5, FETCH = 3'd6, HALT = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] op_pc = '0, target = 8'h40;
  logic [2:0] mode = JUMP;
  logic       cond = 0, bus_req = 0, bus_ack = 0, irq = 0, ie = 0, cont = 0;
  logic [7:0] upc;
  logic       stall, irq_taken, halted;

  typedef struct {
    int         id;
    logic [7:0] upc;
    logic       stall;
    logic       irqt;
    logic       halted;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  scmp_microcode_seq dut (
    .clk(clk), .rst_n(rst_n), .op_pc(op_pc), .mode(mode), .target(target),
    .cond(cond), .bus_req(bus_req), .bus_ack(bus_ack), .irq(irq), .ie(ie),
    .cont(cont), .upc(upc), .stall(stall), .irq_taken(irq_taken), .halted(halted)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the rising edge and queue what the
  // outputs must show during that cycle.
  task automatic cyc(input logic r, input logic [2:0] m, input logic [7:0] t,
                     input logic [7:0] op, input logic c, input logic rq,
                     input logic ak, input logic iq, input logic e, input logic ct,
                     input logic [7:0] eu, input logic es, input logic ei,
                     input logic eh);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n = r; mode = m; target = t; op_pc = op; cond = c;
    bus_req = rq; bus_ack = ak; irq = iq; ie = e; cont = ct;
    step_id++;
    x.id = step_id; x.upc = eu; x.stall = es; x.irqt = ei; x.halted = eh;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      checks++;
      if (upc !== x.upc || stall !== x.stall || irq_taken !== x.irqt ||
          halted !== x.halted) begin
        errors++;
        $display("FAIL step%0d: got upc=%h stall=%b irq_taken=%b halted=%b, expected upc=%h stall=%b irq_taken=%b halted=%b",
                 x.id, upc, stall, irq_taken, halted, x.upc, x.stall, x.irqt, x.halted);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //  rst mode  tgt    op     c  rq ak iq ie ct   upc    st ir hl
    // Reset held 3 clocks with JUMP 40 presented
    cyc(0, JUMP,  8'h40, 8'h00, 0, 0, 0, 0, 0, 0,  8'h00, 0, 0, 0);
    cyc(0, JUMP,  8'h40, 8'h00, 0, 0, 0, 0, 0, 0,  8'h00, 0, 0, 0);
    cyc(0, JUMP,  8'h40, 8'h00, 0, 0, 0, 0, 0, 0,  8'h00, 0, 0, 0);
    cyc(1, NEXT,  8'h00, 8'h00, 0, 0, 0, 0, 0, 0,  8'h00, 0, 0, 0);
    // Call / return / dispatch / wrap / cond
    cyc(1, JUMP,  8'h0A, 8'h00, 0, 0, 0, 0, 0, 0,  8'h01, 0, 0, 0);
    cyc(1, CALL,  8'h1E, 8'h00, 0, 0, 0, 0, 0, 0,  8'h0A, 0, 0, 0);
    cyc(1, RET,   8'h00, 8'h00, 0, 0, 0, 0, 0, 0,  8'h1E, 0, 0, 0);
    cyc(1, DISP,  8'h00, 8'h55, 0, 0, 0, 0, 0, 0,  8'h0B, 0, 0, 0);
    cyc(1, JUMP,  8'hFF, 8'h00, 0, 0, 0, 0, 0, 0,  8'h55, 0, 0, 0);
    cyc(1, NEXT,  8'h00, 8'h00, 0, 0, 0, 0, 0, 0,  8'hFF, 0, 0, 0);
    cyc(1, CONDM, 8'h33, 8'h00, 0, 0, 0, 0, 0, 0,  8'h00, 0, 0, 0);
    cyc(1, CONDM, 8'h33, 8'h00, 1, 0, 0, 0, 0, 0,  8'h01, 0, 0, 0);
    cyc(1, JUMP,  8'h14, 8'h00, 0, 0, 0, 0, 0, 0,  8'h33, 0, 0, 0);
    // Bus wait: 3 stalled cycles, then ack
    cyc(1, NEXT,  8'h00, 8'h00, 0, 1, 0, 0, 0, 0,  8'h14, 1, 0, 0);
    cyc(1, NEXT,  8'h00, 8'h00, 0, 1, 0, 0, 0, 0,  8'h14, 1, 0, 0);
    cyc(1, NEXT,  8'h00, 8'h00, 0, 1, 0, 0, 0, 0,  8'h14, 1, 0, 0);
    cyc(1, NEXT,  8'h00, 8'h00, 0, 1, 1, 0, 0, 0,  8'h14, 0, 0, 0);
    cyc(1, JUMP,  8'h14, 8'h00, 0, 0, 0, 0, 0, 0,  8'h15, 0, 0, 0);
    // Zero-wait bus cycle
    cyc(1, NEXT,  8'h00, 8'h00, 0, 1, 1, 0, 0, 0,  8'h14, 0, 0, 0);
    cyc(1, NEXT,  8'h00, 8'h00, 0, 0, 0, 0, 0, 0,  8'h15, 0, 0, 0);
    // Interrupt at fetch
    cyc(1, FETCH, 8'h00, 8'h00, 0, 0, 0, 1, 0, 0,  8'h16, 0, 0, 0);
    cyc(1, FETCH, 8'h00, 8'h00, 0, 0, 0, 1, 1, 0,  8'h01, 0, 0, 0);
    cyc(1, NEXT,  8'h00, 8'h00, 0, 0, 0, 1, 1, 0,  8'h02, 0, 1, 0);
    cyc(1, NEXT,  8'h00, 8'h00, 0, 0, 0, 1, 1, 0,  8'h03, 0, 0, 0);
    cyc(1, JUMP,  8'h32, 8'h00, 0, 0, 0, 0, 0, 0,  8'h04, 0, 0, 0);
    // HALT at 50, irq does not release, cont does
    cyc(1, HALT,  8'h00, 8'h00, 0, 0, 0, 1, 1, 0,  8'h32, 1, 0, 0);
    for (int i = 0; i < 5; i++)
      cyc(1, NEXT, 8'h00, 8'h00, 0, 0, 0, 1, 1, 0, 8'h32, 1, 0, 1);
    cyc(1, NEXT,  8'h00, 8'h00, 0, 0, 0, 0, 0, 1,  8'h32, 0, 0, 1);
    cyc(1, NEXT,  8'h00, 8'h00, 0, 0, 0, 0, 0, 0,  8'h33, 0, 0, 0);
    // FETCH with bus wait: irq sampled on the ack cycle
    cyc(1, FETCH, 8'h00, 8'h00, 0, 1, 0, 0, 1, 0,  8'h34, 1, 0, 0);
    cyc(1, FETCH, 8'h00, 8'h00, 0, 1, 1, 1, 1, 0,  8'h34, 0, 0, 0);
    cyc(1, NEXT,  8'h00, 8'h00, 0, 0, 0, 0, 0, 0,  8'h02, 0, 1, 0);
    cyc(1, JUMP,  8'h40, 8'h00, 0, 0, 0, 0, 0, 0,  8'h03, 0, 0, 0);
    // HALT with bus cycle: bus completes, HALT entered on the ack cycle
    cyc(1, HALT,  8'h00, 8'h00, 0, 1, 0, 0, 0, 0,  8'h40, 1, 0, 0);
    cyc(1, HALT,  8'h00, 8'h00, 0, 1, 1, 0, 0, 0,  8'h40, 1, 0, 0);
    cyc(1, NEXT,  8'h00, 8'h00, 0, 0, 0, 0, 0, 0,  8'h40, 1, 0, 1);
    // Reset while HALTED; ret (was 0B) must read back as 0
    cyc(0, NEXT,  8'h00, 8'h00, 0, 0, 0, 0, 0, 0,  8'h40, 0, 0, 1);
    cyc(1, RET,   8'h00, 8'h00, 0, 0, 0, 0, 0, 0,  8'h00, 0, 0, 0);
    cyc(1, JUMP,  8'h60, 8'h00, 0, 0, 0, 0, 0, 0,  8'h00, 0, 0, 0);
    // Reset while in BUSWAIT, no ack ever given
    cyc(1, NEXT,  8'h00, 8'h00, 0, 1, 0, 0, 0, 0,  8'h60, 1, 0, 0);
    cyc(1, NEXT,  8'h00, 8'h00, 0, 1, 0, 0, 0, 0,  8'h60, 1, 0, 0);
    cyc(0, NEXT,  8'h00, 8'h00, 0, 1, 0, 0, 0, 0,  8'h60, 0, 0, 0);
    cyc(1, NEXT,  8'h00, 8'h00, 0, 0, 0, 0, 0, 0,  8'h00, 0, 0, 0);
    cyc(1, NEXT,  8'h00, 8'h00, 0, 0, 0, 0, 0, 0,  8'h01, 0, 0, 0);

    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scmp_microcode_seq.md
Name: scmp_microcode_seq

Overview:
Micro-program counter sequencer for the SC/MP core. Each cycle it selects the next microcode ROM address from these sources:
- the current micro-PC
- a ROM-supplied target
- the opcode dispatch label
- a one-entry return register
- the fixed fetch/interrupt/reset vectors

It stalls on external bus handshakes and HALT. It also takes the interrupt decision at the instruction-fetch boundary. It sits between the opcode dispatch decoder and the microcode ROM.

Parameters:
UPC_W, 8, micro-PC width in bits.
RESET_ADDR, 8'h00, micro-PC loaded by reset.
FETCH_ADDR, 8'h01, micro-PC of the instruction-fetch routine.
INT_ADDR, 8'h02, micro-PC of the interrupt-entry routine.

Ports:
clk  in  1  system clock; all state changes on rising edge.
rst_n  in  1  synchronous active-low reset.
op_pc  in  UPC_W  dispatch label from the opcode decoder.
mode  in  3  next-address mode field of the current microword.
target  in  UPC_W  branch/call target field of the current microword.
cond  in  1  selected branch condition, valid while mode=COND.
bus_req  in  1  current microword starts a bus cycle.
bus_ack  in  1  bus cycle complete, sampled each cycle.
irq  in  1  level interrupt request (SENSE A).
ie  in  1  interrupt enable flag from the status register.
cont  in  1  continue request, releases HALT.
upc  out  UPC_W  current micro-PC; ROM address.
stall  out  1  combinational: sequencer will not advance this cycle.
irq_taken  out  1  registered one-cycle pulse: interrupt vector taken.
halted  out  1  registered: sequencer parked in HALT.

Behaviour:
Reset:
- Applies when rst_n=0 at a clock edge.
- upc<=RESET_ADDR, ret<=0, irq_taken<=0, halted<=0.
- Overrides any stall, HALT or pending bus cycle. The bus cycle in flight is abandoned, with no wait for ack.

State machine:
- RUN: evaluate the microword each cycle.
- BUSWAIT: a bus cycle is outstanding.
- HALTED: parked, waiting for cont.
- Reset enters RUN.

RUN, bus_req=1 and bus_ack=0:
- upc holds and stall=1.
- Next state is BUSWAIT.
- The mode is not evaluated.

RUN, bus_req=1 and bus_ack=1 in the same cycle:
- The cycle is zero-wait. Advance per mode this cycle, with stall=0.

BUSWAIT:
- upc holds and stall=1 while bus_ack=0.
- When bus_ack=1: advance per the (unchanged) mode that cycle, stall=0, return to RUN.

Modes, evaluated only when not stalled. "+1" is modulo 2^UPC_W, so FF wraps to 00.
- 0 NEXT: upc+1.
- 1 JUMP: target.
- 2 DISPATCH: op_pc.
- 3 COND: target if cond=1, else upc+1.
- 4 CALL: ret<=upc+1; upc<=target. A second CALL overwrites ret (no nesting).
- 5 RET: ret. ret is unchanged.
- 6 FETCH: INT_ADDR if (irq & ie), else FETCH_ADDR.
  - irq_taken=1 for exactly the cycle after the INT_ADDR load.
  - Interrupts are recognised only here.
- 7 HALT: upc holds, halted<=1, state HALTED, stall=1.

HALTED:
- upc holds, stall=1, halted=1.
- When cont=1: upc<=upc+1, halted<=0, go to RUN, stall=0.
- irq does not release HALT.

Simultaneous events:
- Bus stall takes priority over mode.
- HALT with bus_req: the bus cycle completes first, then HALT is entered on the ack cycle.
- FETCH with bus_req: the irq/ie sample is taken on the advancing cycle.

irq_taken is 0 in every cycle other than the one defined above.

The sequencer accepts any op_pc value without check.

Test Plan:
- Reset release: hold rst_n=0 for 3 clocks with mode=JUMP, target=8'h40, then release → upc=8'h00 during reset. First advance uses mode NEXT → upc=8'h01. irq_taken=0 and halted=0 throughout.
- Dispatch/call/return: upc=10, CALL target=30 → upc=30 and ret=11. Next RET → upc=11. DISPATCH with op_pc=8'h55 → upc=8'h55. NEXT at upc=8'hFF → upc=8'h00.
- Bus wait: bus_req=1 with mode=NEXT at upc=20, bus_ack low for 3 cycles → upc stays 20 with stall=1 for 3 cycles. On the ack cycle stall=0, then upc=21. Zero-wait variant (req and ack together) → upc=21 next cycle with stall never 1.
- Interrupt at fetch:
  - irq=1, ie=0, FETCH → upc=FETCH_ADDR, no pulse.
  - irq=1, ie=1, FETCH → upc=INT_ADDR with irq_taken high exactly one cycle.
  - irq=1 during NEXT → no vectoring.
- HALT: mode=HALT at upc=50 → halted=1 and upc stays 50 for 5 cycles despite irq=1. cont=1 → upc=51 and halted=0.
- Reset mid-operation: assert rst_n=0 in BUSWAIT, and separately in HALTED → upc=RESET_ADDR, stall=0, halted=0 and ret=0 next cycle, with no bus_ack required.
